// File: rtl/alu_dispatch.sv
// Decode/dispatch stage in front of the integer ALU: decodes OP and OP-IMM
// instructions into ALU op/operands and queues them in a 2-entry FIFO.
module alu_dispatch #(
   parameter int DATA_WIDTH = 32,
   parameter bit RVE        = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           instr,
   input  logic [DATA_WIDTH-1:0] rs1_data,
   input  logic [DATA_WIDTH-1:0] rs2_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [3:0]            alu_op,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic [4:0]            alu_rd,
   output logic                  illegal
);

   localparam logic [6:0] OPC_OP  = 7'b0110011;
   localparam logic [6:0] OPC_IMM = 7'b0010011;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [3:0] ALU_SLL = 4'b0001;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b1000;
   localparam logic [3:0] ALU_SRA = 4'b1101;
   localparam logic [3:0] ALU_ILL = 4'b1111;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [DATA_WIDTH-1:0] imm;
   logic [DATA_WIDTH-1:0] shamt;
   logic rve_bad;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign imm    = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
   assign shamt  = {{(DATA_WIDTH-5){1'b0}}, instr[24:20]};

   // Reduced register file: any register field actually used must be below 16.
   assign rve_bad = RVE && ((instr[11:7] >= 5'd16) || (instr[19:15] >= 5'd16) ||
                            ((opcode == OPC_OP) && (instr[24:20] >= 5'd16)));

   logic                  legal;
   logic [3:0]            sel_op;
   logic [DATA_WIDTH-1:0] sel_b;
   logic [3:0]            dec_op;
   logic [DATA_WIDTH-1:0] dec_a;
   logic [DATA_WIDTH-1:0] dec_b;
   logic                  dec_ill;

   always_comb begin
      legal  = 1'b0;
      sel_op = ALU_ILL;
      sel_b  = '0;
      case (opcode)
         OPC_OP: begin
            sel_b = rs2_data;
            if (funct7 == F7_BASE) begin
               legal  = 1'b1;
               sel_op = {1'b0, funct3};
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
               legal  = 1'b1;
               sel_op = ALU_SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
               legal  = 1'b1;
               sel_op = ALU_SRA;
            end
         end
         OPC_IMM: begin
            case (funct3)
               3'b001: begin
                  sel_b  = shamt;
                  sel_op = ALU_SLL;
                  legal  = (funct7 == F7_BASE);
               end
               3'b101: begin
                  sel_b = shamt;
                  if (funct7 == F7_BASE) begin
                     legal  = 1'b1;
                     sel_op = ALU_SRL;
                  end else if (funct7 == F7_ALT) begin
                     legal  = 1'b1;
                     sel_op = ALU_SRA;
                  end
               end
               default: begin
                  sel_b  = imm;
                  sel_op = {1'b0, funct3};
                  legal  = 1'b1;
               end
            endcase
         end
         default: legal = 1'b0;
      endcase
   end

   // Illegal encodings still travel through the queue, but with neutral operands.
   always_comb begin
      if (legal && !rve_bad) begin
         dec_op  = sel_op;
         dec_a   = rs1_data;
         dec_b   = sel_b;
         dec_ill = 1'b0;
      end else begin
         dec_op  = ALU_ILL;
         dec_a   = '0;
         dec_b   = '0;
         dec_ill = 1'b1;
      end
   end

   logic [3:0]            op_q  [2];
   logic [DATA_WIDTH-1:0] a_q   [2];
   logic [DATA_WIDTH-1:0] b_q   [2];
   logic [4:0]            rd_q  [2];
   logic                  ill_q [2];
   logic [1:0]            count;
   logic                  head;
   logic                  tail;
   logic                  push;
   logic                  pop;

   assign in_ready  = !reset && (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign alu_op  = op_q[head];
   assign alu_a   = a_q[head];
   assign alu_b   = b_q[head];
   assign alu_rd  = rd_q[head];
   assign illegal = ill_q[head];

   // Entries are cleared on reset so the idle head reads back as all zeros.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= 2'd0;
         head  <= 1'b0;
         tail  <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            op_q[i]  <= '0;
            a_q[i]   <= '0;
            b_q[i]   <= '0;
            rd_q[i]  <= '0;
            ill_q[i] <= 1'b0;
         end
      end else begin
         if (push) begin
            op_q[tail]  <= dec_op;
            a_q[tail]   <= dec_a;
            b_q[tail]   <= dec_b;
            rd_q[tail]  <= instr[11:7];
            ill_q[tail] <= dec_ill;
            tail        <= ~tail;
         end
         if (pop) begin
            head <= ~head;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Decode/dispatch stage directly upstream of the integer ALU. It accepts OP (0110011) and OP-IMM (0010011) instructions together with their register operands over a valid/ready handshake. It decodes each one into the ALU's 4-bit op code and its A/B operands, and holds the results in a 2-entry output buffer. It presents them to the ALU side with its own valid/ready handshake and flags encodings the ALU must not execute.

## Interface
Parameters:
- DATA_WIDTH, 32, operand width. Only 32 is supported.
- RVE, 0, when 1, any used register field (rd, rs1, and rs2 for OP) of 16 or more is illegal.

Ports:
- clk  in  1  clock. Everything is sampled on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  an instruction is offered.
- in_ready  out  1  the block can accept. Equals (count != 2).
- instr  in  32  instruction word.
- rs1_data  in  DATA_WIDTH  value of register rs1.
- rs2_data  in  DATA_WIDTH  value of register rs2 (ignored for OP-IMM).
- out_valid  out  1  the head entry is valid.
- out_ready  in  1  the consumer accepts the head entry.
- alu_op  out  4  ALU operation code.
- alu_a  out  DATA_WIDTH  operand A.
- alu_b  out  DATA_WIDTH  operand B.
- alu_rd  out  5  destination register.
- illegal  out  1  the entry is an illegal encoding.

## Operation
- Accept occurs when in_valid & in_ready. The instruction is decoded combinationally and written to the buffer tail in that cycle. rs1_data and rs2_data are captured at accept only.
- Output occurs when out_valid & out_ready. The head entry is popped.
- ALU op codes: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101.
- OP decode:
  - funct7 = 0000000 gives op = {0, funct3}.
  - funct7 = 0100000 with funct3 000 gives SUB; with funct3 101 gives SRA.
  - Any other funct7/funct3 combination is illegal.
  - alu_a = rs1_data, alu_b = rs2_data.
- OP-IMM decode:
  - alu_a = rs1_data.
  - imm = sign-extended instr[31:20].
  - funct3 001 (SLLI): requires instr[31:25] = 0. op = SLL, alu_b = zero-extended instr[24:20].
  - funct3 101 with instr[31:25] = 0000000: SRL. With instr[31:25] = 0100000: SRA. Otherwise illegal. alu_b = zero-extended instr[24:20].
  - Other funct3 values: op = {0, funct3}, alu_b = imm. Bit 30 never selects SUB.
- Any other opcode is illegal.
- An illegal entry is still queued and delivered in order, with illegal = 1, alu_op = 1111, alu_a = 0, alu_b = 0, and alu_rd = instr[11:7].
- Buffer:
  - Two entries, FIFO order, with a 2-bit count (0..2) and 1-bit head/tail pointers that wrap modulo 2.
  - Push only: count + 1. Pop only: count - 1. Push and pop in the same cycle: count unchanged and both pointers advance.
  - Push is impossible at count 2 because in_ready = 0.
  - Pop at count 0 is impossible because out_valid = 0. out_ready is then ignored.
- The head entry outputs are stable while out_valid & !out_ready.

## Timing
- Reset values: count = 0, pointers = 0, out_valid = 0, alu_op = 0, alu_a = 0, alu_b = 0, alu_rd = 0, illegal = 0.
- in_ready = 1 from the first cycle after reset deasserts.
- While reset is high:
  - in_ready is forced to 0.
  - Any offered instruction is not accepted.
  - Any entry in the buffer is discarded, including when reset is asserted mid-stream.
- Latency: an instruction accepted at edge N (buffer empty) has out_valid = 1 after edge N, i.e. one cycle. There is no combinational path from in_* to out_*.
- Throughput: one instruction per cycle while out_ready is held 1.
- Backpressure: with out_ready = 0, two instructions are accepted, then in_ready drops. in_ready returns to 1 the cycle after the first pop.
- There is no combinational path from out_ready to in_ready. in_ready depends only on registered count and reset.

## Test plan
- Reset then ADDI x5, x1, -1 (0xFFF08293) with rs1_data = 10, out_ready = 1 -> one cycle later: out_valid = 1, alu_op = 0000, alu_a = 10, alu_b = 0xFFFFFFFF, alu_rd = 5, illegal = 0.
- OP decode: SUB x3, x1, x2 (0x402081B3) with rs1_data = 7, rs2_data = 9 -> alu_op = 1000, alu_a = 7, alu_b = 9. SRAI x3, x1, 4 (0x4040D193) -> alu_op = 1101, alu_b = 4.
- Illegal encodings: OP funct7 = 0000001 (MUL, 0x022081B3), SLLI with instr[30] = 1, and opcode 0000011 -> illegal = 1, alu_op = 1111, alu_a = 0, alu_b = 0, delivered in order. With RVE = 1, ADD x17, x1, x2 -> illegal = 1.
- Backpressure: out_ready = 0 and three back-to-back offers -> two accepted, in_ready = 0 at count 2. Raising out_ready delivers entries 1, 2, 3 in order, with outputs unchanged while stalled.
- Simultaneous push and pop at count 1 for 10 cycles -> count stays 1, no drop or duplication, and the output sequence matches the input sequence across pointer wrap.
- Reset asserted with count = 2 -> the next cycle has out_valid = 0 and all outputs 0. An instruction offered during reset is never delivered.
